// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the memory BIST sequencer.
package mbist_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {OP_R0, OP_R1, OP_W0, OP_W1} op_t;

  localparam int NUM_ELEM = 6;
  localparam int ELEM_W   = 3;

  typedef struct packed {
    logic dn;       // 1: addresses run from all-1 down to 0
    logic two_ops;  // 1: op0 then op1 on the same address
    op_t  op0;
    op_t  op1;
  } elem_t;

  // {UP(w0); UP(r0,w1); UP(r1,w0); DN(r0,w1); DN(r1,w0); UP(r0)}
  function automatic elem_t elem_lookup(input logic [ELEM_W-1:0] idx);
    case (idx)
      3'd0:    elem_lookup = '{1'b0, 1'b0, OP_W0, OP_W0};
      3'd1:    elem_lookup = '{1'b0, 1'b1, OP_R0, OP_W1};
      3'd2:    elem_lookup = '{1'b0, 1'b1, OP_R1, OP_W0};
      3'd3:    elem_lookup = '{1'b1, 1'b1, OP_R0, OP_W1};
      3'd4:    elem_lookup = '{1'b1, 1'b1, OP_R1, OP_W0};
      default: elem_lookup = '{1'b0, 1'b0, OP_R0, OP_R0};
    endcase
  endfunction

  function automatic logic is_read(input op_t op);
    return (op == OP_R0) || (op == OP_R1);
  endfunction

  // Background value carried by an op: r1/w1 use all-1, r0/w0 all-0.
  function automatic logic op_bg(input op_t op);
    return (op == OP_R1) || (op == OP_W1);
  endfunction

endpackage

// File: rtl/mbist_counter.sv
// Loadable up/down counter used as the BIST address generator.
module mbist_counter #(
  parameter int LENGTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [LENGTH-1:0] d_in,
  input  logic              cen,
  input  logic              u_d,
  output logic [LENGTH-1:0] q,
  output logic              cout
);

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (ld)   q <= d_in;
    else if (cen)  q <= u_d ? q + 1'b1 : q - 1'b1;
  end

  assign cout = u_d ? (&q) : ~(|q);

endmodule

// File: rtl/mbist_controller.sv
// March C- BIST sequencer for one single-port synchronous SRAM.
// Define MBIST_FAIL_LOG_EN to add the first-mismatch log (fail_addr, fail_data).
module mbist_controller
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass
`ifdef MBIST_FAIL_LOG_EN
  ,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
`endif
);

  state_t              state_q, state_d;
  logic [ELEM_W-1:0]   elem_q, elem_d;
  logic                op_q, op_d;
  logic                done_q, mismatch_q;
  logic                cmp_valid_q, cmp_exp_q;
  elem_t               elem;
  op_t                 cur_op;
  logic                last_op, at_term, start_ok, cmp_fail;
  logic                cnt_ld, cnt_cen, cnt_ud, cnt_cout;
  logic [ADDR_W-1:0]   cnt_d;

  mbist_counter #(.LENGTH(ADDR_W)) u_addr_cnt (
    .clk  (clk),
    .rst  (rst),
    .ld   (cnt_ld),
    .d_in (cnt_d),
    .cen  (cnt_cen),
    .u_d  (cnt_ud),
    .q    (mem_addr),
    .cout (cnt_cout)
  );

  always_comb begin
    elem    = elem_lookup(elem_q);
    cur_op  = op_q ? elem.op1 : elem.op0;
    last_op = !elem.two_ops || op_q;
    at_term = elem.dn ? (mem_addr == '0) : (mem_addr == '1);
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    op_d    = op_q;
    cnt_ld  = 1'b0;
    cnt_d   = {ADDR_W{elem.dn}};
    cnt_cen = 1'b0;
    cnt_ud  = !elem.dn;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        elem_d  = '0;
        op_d    = 1'b0;
      end
      LOAD: begin
        cnt_ld  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        mem_re = is_read(cur_op);
        mem_we = !is_read(cur_op);
        if (!last_op) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          // Element ends on the terminal address; wrap only happens through LOAD.
          if (!at_term) begin
            cnt_cen = 1'b1;
          end else if (elem_q == ELEM_W'(NUM_ELEM - 1)) begin
            state_d = DRAIN;
          end else begin
            elem_d  = elem_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign start_ok  = (state_q == IDLE) && start;
  assign cmp_fail  = cmp_valid_q && (mem_rdata != {DATA_W{cmp_exp_q}});
  assign mem_wdata = mem_we ? {DATA_W{op_bg(cur_op)}} : '0;
  assign busy      = state_q inside {LOAD, RUN, DRAIN};
  assign done      = done_q;
  assign pass      = done_q && !mismatch_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      elem_q  <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      op_q    <= op_d;
    end
  end

  // A read in cycle N is checked against its expected background in cycle N+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= 1'b0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      cmp_valid_q <= mem_re;
      cmp_exp_q   <= op_bg(cur_op);
      if (start_ok) begin
        done_q     <= 1'b0;
        mismatch_q <= 1'b0;
      end else begin
        if (state_q == DRAIN) done_q     <= 1'b1;
        if (cmp_fail)         mismatch_q <= 1'b1;
      end
    end
  end

`ifdef MBIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] cmp_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_addr_q <= '0;
      fail_addr  <= '0;
      fail_data  <= '0;
    end else begin
      cmp_addr_q <= mem_addr;
      if (start_ok) begin
        fail_addr <= '0;
        fail_data <= '0;
      end else if (cmp_fail && !mismatch_q) begin
        fail_addr <= cmp_addr_q;
        fail_data <= mem_rdata;
      end
    end
  end
`endif

  // The counter's own terminal flag must agree with the address compare.
  always_ff @(posedge clk) begin
    if (!rst && state_q == RUN && last_op && at_term) assert (cnt_cout);
  end

endmodule

// File: tb/tb_mbist_controller.sv
// Self-checking bench for mbist_controller: March C- reference model plus behavioural SRAM.
module tb_mbist_controller;

  localparam int AW      = 4;
  localparam int DW      = 8;
  localparam int DEPTH   = 1 << AW;
  localparam int LATENCY = 10 * DEPTH + 8;
  localparam int BUS_W   = 2 + AW + DW;

  // March C- written out: direction, op count, ops (0=r0 1=r1 2=w0 3=w1).
  localparam int M_DN   [6]    = '{0, 0, 0, 1, 1, 0};
  localparam int M_NOPS [6]    = '{1, 2, 2, 2, 2, 1};
  localparam int M_OPS  [6][2] = '{'{2, 2}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, 0}};

  typedef logic [BUS_W-1:0] bus_t;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, done, pass;
`ifdef MBIST_FAIL_LOG_EN
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
`endif

  always #5 clk = ~clk;

  mbist_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .pass      (pass)
`ifdef MBIST_FAIL_LOG_EN
    ,
    .fail_addr (fail_addr),
    .fail_data (fail_data)
`endif
  );

  // Behavioural SRAM with per-bit stuck-at masks applied to stored data.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] sa0 [DEPTH];
  logic [DW-1:0] sa1 [DEPTH];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= (mem_wdata & ~sa0[mem_addr]) | sa1[mem_addr];
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  bus_t          exp_bus[$];
  logic          exp_pass;
  logic [AW-1:0] exp_faddr;
  logic [DW-1:0] exp_fdata;

  // Expected per-cycle bus activity from the start edge to DONE, and the expected verdict.
  task automatic build_model();
    logic [DW-1:0] mm [DEPTH];
    logic [AW-1:0] a;
    logic [DW-1:0] pat;
    int            op;
    exp_bus.delete();
    exp_pass  = 1'b1;
    exp_faddr = '0;
    exp_fdata = '0;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    for (int e = 0; e < 6; e++) begin
      exp_bus.push_back('0);
      for (int i = 0; i < DEPTH; i++) begin
        a = (M_DN[e] != 0) ? AW'(DEPTH - 1 - i) : AW'(i);
        for (int k = 0; k < M_NOPS[e]; k++) begin
          op  = M_OPS[e][k];
          pat = (op == 1 || op == 3) ? '1 : '0;
          if (op < 2) begin
            exp_bus.push_back({1'b0, 1'b1, a, {DW{1'b0}}});
            if (mm[a] !== pat && exp_pass) begin
              exp_pass  = 1'b0;
              exp_faddr = a;
              exp_fdata = mm[a];
            end
          end else begin
            exp_bus.push_back({1'b1, 1'b0, a, pat});
            mm[a] = (pat & ~sa0[a]) | sa1[a];
          end
        end
      end
    end
    exp_bus.push_back('0);
  endtask

  function automatic bus_t act_bus();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = (mem_we || mem_re) ? mem_addr : '0;
    d = mem_we ? mem_wdata : '0;
    return {mem_we, mem_re, a, d};
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < DEPTH; i++) begin
      sa0[i] = '0;
      sa1[i] = '0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 64'(mem_addr), 0);
    check({tag, "_we_re"}, {mem_we, mem_re}, 0);
    check({tag, "_wdata"}, 64'(mem_wdata), 0);
    check({tag, "_busy_done_pass"}, {busy, done, pass}, 0);
`ifdef MBIST_FAIL_LOG_EN
    check({tag, "_fail_log"}, {fail_addr, fail_data}, 0);
`endif
  endtask

  // One run: pulse start, compare every cycle to the model, optionally re-pulse start or reset.
  task automatic run_march(input string tag, input int dup_start_at, input int rst_at);
    int done_cyc;
    build_model();
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= LATENCY + 40; cyc++) begin
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        check_all_zero({tag, "_abort"});
        return;
      end
      if (cyc == 1) begin
        check({tag, "_clear_on_start"}, {done, pass}, 0);
`ifdef MBIST_FAIL_LOG_EN
        check({tag, "_fail_log_clear"}, {fail_addr, fail_data}, 0);
`endif
      end
      if (cyc <= exp_bus.size()) begin
        check($sformatf("%s_c%0d", tag, cyc), {busy, done, act_bus()},
              {2'b10, exp_bus[cyc-1]});
      end else if (done) begin
        done_cyc = cyc;
        break;
      end
      start = (cyc == dup_start_at);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(done_cyc), 64'(LATENCY));
    if (done_cyc > 0) begin
      check({tag, "_done_quiet"}, {busy, mem_we, mem_re}, 0);
      check({tag, "_pass"}, pass, exp_pass);
`ifdef MBIST_FAIL_LOG_EN
      check({tag, "_fail_addr"}, 64'(fail_addr), 64'(exp_faddr));
      check({tag, "_fail_data"}, 64'(fail_data), 64'(exp_fdata));
`endif
      @(negedge clk);
      check({tag, "_done_sticky"}, {done, busy, pass}, {2'b10, exp_pass});
    end
  endtask

  initial begin
    int kind, fa, fb;
    rst   = 1'b1;
    start = 1'b0;
    clear_faults();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    run_march("t1_clean", 0, 0);

    sa0[5] = 8'h08;
    run_march("t2_sa0", 0, 0);
    check("t2_pass_const", pass, 0);
`ifdef MBIST_FAIL_LOG_EN
    check("t2_fail_addr_const", 64'(fail_addr), 5);
    check("t2_fail_data_const", 64'(fail_data), 8'hF7);
`endif

    clear_faults();
    run_march("t6_back_to_back", 0, 0);

    run_march("t4_dup_start", 50, 0);

    run_march("t5_abort", 0, 70);
    @(posedge clk);
    @(negedge clk);
    check_all_zero("t5_held");
    rst = 1'b0;
    run_march("t5_rerun", 0, 0);

    for (int r = 0; r < 6; r++) begin
      clear_faults();
      kind = int'($urandom_range(0, 2));
      fa   = int'($urandom_range(0, DEPTH - 1));
      fb   = int'($urandom_range(0, DW - 1));
      if (kind == 1) sa0[fa][fb] = 1'b1;
      if (kind == 2) sa1[fa][fb] = 1'b1;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_march($sformatf("rnd%0d_k%0d_a%0d_b%0d", r, kind, fa, fb), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
